// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the VGA timing generator.
// Default timing is 800x600@60 Hz with a 40 MHz pixel clock.
package vga_timing_pkg;

    localparam int CNT_W     = 11;
    localparam int FRAME_W   = 16;
    localparam int MAX_TOTAL = 2048;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FP     = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BP     = 2'd3
    } axis_state_e;

    function automatic axis_state_e next_region(input axis_state_e s);
        case (s)
            ST_ACTIVE: return ST_FP;
            ST_FP:     return ST_SYNC;
            ST_SYNC:   return ST_BP;
            default:   return ST_ACTIVE;
        endcase
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus ACTIVE/FP/SYNC/BP region FSM.
// sync/blnk are registered from the next count so they line up with count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE   = DEF_H_ACTIVE,
    parameter int FP       = DEF_H_FP,
    parameter int SYNC     = DEF_H_SYNC,
    parameter int BP       = DEF_H_BP,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             blnk,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST_ACT  = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FP   = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_TOT  = CNT_W'(TOTAL - 1);

    if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_zero_param
        $error("vga_axis_counter: timing parameters must be non-zero");
    end
    if (TOTAL > MAX_TOTAL) begin : g_total_too_big
        $error("vga_axis_counter: total exceeds 11-bit counter range");
    end

    axis_state_e      r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_sync;
    logic             r_blnk;

    axis_state_e      w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_last;
    logic             w_sync_nxt;
    logic             w_blnk_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_ACTIVE;
            r_count <= '0;
            r_sync  <= ~SYNC_POL;
            r_blnk  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_sync  <= w_sync_nxt;
            r_blnk  <= w_blnk_nxt;
        end
    end

    // A region ends when the count sits on that region's last value.
    always_comb begin
        w_last      = LAST_TOT;
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            ST_ACTIVE: w_last = LAST_ACT;
            ST_FP:     w_last = LAST_FP;
            ST_SYNC:   w_last = LAST_SYNC;
            default:   w_last = LAST_TOT;
        endcase
        if (inc) begin
            w_count_nxt = (r_count == LAST_TOT) ? '0 : r_count + 1'b1;
            if (r_count == w_last) begin
                w_state_nxt = next_region(r_state);
            end
        end
    end

    always_comb begin
        w_blnk_nxt = (w_state_nxt != ST_ACTIVE);
        w_sync_nxt = (w_state_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    end

    assign wrap  = inc && (r_count == LAST_TOT);
    assign count = r_count;
    assign sync  = r_sync;
    assign blnk  = r_blnk;

endmodule

// File: rtl/vga_timing.sv
// VGA timing source: horizontal and vertical axis counters chained on line end,
// plus a frame-start strobe and frame counter for game-logic pacing.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    output logic [CNT_W-1:0]   hcount_out,
    output logic               hsync_out,
    output logic               hblnk_out,
    output logic [CNT_W-1:0]   vcount_out,
    output logic               vsync_out,
    output logic               vblnk_out,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_v_inc;
    logic               w_frame_wrap;
    logic               r_frame_start;
    logic [FRAME_W-1:0] r_frame_cnt;

    vga_axis_counter #(
        .ACTIVE  (H_ACTIVE),
        .FP      (H_FP),
        .SYNC    (H_SYNC),
        .BP      (H_BP),
        .SYNC_POL(SYNC_POL)
    ) u_h_axis (
        .clk  (clk),
        .rst  (rst),
        .inc  (ce),
        .count(hcount_out),
        .sync (hsync_out),
        .blnk (hblnk_out),
        .wrap (w_h_wrap)
    );

    assign w_v_inc = ce & w_h_wrap;

    vga_axis_counter #(
        .ACTIVE  (V_ACTIVE),
        .FP      (V_FP),
        .SYNC    (V_SYNC),
        .BP      (V_BP),
        .SYNC_POL(SYNC_POL)
    ) u_v_axis (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_v_inc),
        .count(vcount_out),
        .sync (vsync_out),
        .blnk (vblnk_out),
        .wrap (w_v_wrap)
    );

    // Both axes wrapping together means the next edge shows (0,0).
    assign w_frame_wrap = w_h_wrap & w_v_wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_frame_start <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing on a reduced timing set, both sync polarities,
// against a model that tracks the linear pixel position within the frame.
module tb_vga_timing;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 10, VF = 1, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce  = 1'b0;

    logic [10:0] hc_p, vc_p, hc_n, vc_n;
    logic        hs_p, hb_p, vs_p, vb_p, fs_p;
    logic        hs_n, hb_n, vs_n, vb_n, fs_n;
    logic [15:0] fc_p, fc_n;

    int n_chk  = 0;
    int n_fail = 0;

    int m_pos  = 0;
    int m_fcnt = 0;
    bit m_fs   = 1'b0;

    always #5 clk = ~clk;

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1)
    ) dut_p (
        .clk(clk), .rst(rst), .ce(ce),
        .hcount_out(hc_p), .hsync_out(hs_p), .hblnk_out(hb_p),
        .vcount_out(vc_p), .vsync_out(vs_p), .vblnk_out(vb_p),
        .frame_start(fs_p), .frame_cnt(fc_p)
    );

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) dut_n (
        .clk(clk), .rst(rst), .ce(ce),
        .hcount_out(hc_n), .hsync_out(hs_n), .hblnk_out(hb_n),
        .vcount_out(vc_n), .vsync_out(vs_n), .vblnk_out(vb_n),
        .frame_start(fs_n), .frame_cnt(fc_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_win(input int x, input int lo, input int len);
        return (x >= lo) && (x < lo + len);
    endfunction

    task automatic check_all(input string ph);
        int h, v;
        h = m_pos % HT;
        v = m_pos / HT;
        chk({ph, ":hcount"}, 32'(hc_p), 32'(h));
        chk({ph, ":vcount"}, 32'(vc_p), 32'(v));
        chk({ph, ":hblnk"},  32'(hb_p), 32'(h >= HA));
        chk({ph, ":vblnk"},  32'(vb_p), 32'(v >= VA));
        chk({ph, ":hsync"},  32'(hs_p), 32'(in_win(h, HA + HF, HS)));
        chk({ph, ":vsync"},  32'(vs_p), 32'(in_win(v, VA + VF, VS)));
        chk({ph, ":fstart"}, 32'(fs_p), 32'(m_fs));
        chk({ph, ":fcnt"},   32'(fc_p), 32'(m_fcnt));
        chk({ph, ":n_hsync"}, 32'(hs_n), 32'(!in_win(h, HA + HF, HS)));
        chk({ph, ":n_vsync"}, 32'(vs_n), 32'(!in_win(v, VA + VF, VS)));
        chk({ph, ":n_blnk"},  32'({hb_n, vb_n}), 32'({h >= HA, v >= VA}));
        chk({ph, ":n_pos"},   32'({vc_n, hc_n, fs_n}), 32'({v[10:0], h[10:0], m_fs}));
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_fcnt = 0;
        m_fs   = 1'b0;
    endtask

    // One clock with the given ce; model advances on the same edge.
    task automatic cyc(input bit c, input string ph);
        ce = c;
        @(posedge clk);
        #1;
        m_fs = 1'b0;
        if (c) begin
            m_pos = (m_pos + 1) % FRAME;
            if (m_pos == 0) begin
                m_fs   = 1'b1;
                m_fcnt = (m_fcnt + 1) % 65536;
            end
        end
        check_all(ph);
    endtask

    initial begin
        int pulses, pulse_at, hs_len, vs_first, vs_last, edges;
        bit seen, c;

        // Reset state
        rst = 1'b0;
        ce  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        rst = 1'b1;

        // One full frame with ce held high
        pulses = 0; pulse_at = -1; hs_len = 0; vs_first = -1; vs_last = -1;
        for (int i = 1; i <= FRAME; i++) begin
            cyc(1'b1, "frame1");
            if (fs_p) begin
                pulses++;
                pulse_at = i;
            end
            if (vc_p == 0 && hs_p) hs_len++;
            if (vs_p && hc_p == 0 && vs_first < 0) vs_first = int'(vc_p);
            if (vs_p && hc_p == 0) vs_last = int'(vc_p);
            if (i > 1 && vs_p !== vs_n ^ 1'b1) chk("sync_pol_mirror", 32'(vs_n), 32'(!vs_p));
        end
        chk("frame1_pulses", 32'(pulses), 32'd1);
        chk("frame1_pulse_cycle", 32'(pulse_at), 32'(FRAME));
        chk("frame1_fcnt", 32'(fc_p), 32'd1);
        chk("line0_hsync_len", 32'(hs_len), 32'(HS));
        chk("vsync_first_line", 32'(vs_first), 32'(VA + VF));
        chk("vsync_last_line", 32'(vs_last), 32'(VA + VF + VS - 1));

        // ce alternating over two frames
        pulses = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            cyc(i[0] == 1'b0, "ce_toggle");
            if (fs_p) pulses++;
        end
        chk("toggle_pulses", 32'(pulses), 32'd2);
        chk("toggle_fcnt", 32'(fc_p), 32'd3);

        // Random ce pacing
        for (int i = 0; i < 3 * FRAME; i++) begin
            cyc($urandom_range(0, 3) != 0, "ce_rand");
        end

        // Run to a mid-frame point, then reset without a clock edge
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            cyc(1'b1, "seek");
            if (m_pos == 6 * HT + 9) seen = 1'b1;
        end
        chk("seek_midframe", 32'(seen), 32'd1);
        rst = 1'b0;
        #2;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst = 1'b1;

        // Count ce cycles from release to the next frame_start
        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            c = ($urandom_range(0, 4) != 0);
            cyc(c, "post_rst");
            if (c) edges++;
            if (fs_p) seen = 1'b1;
        end
        chk("post_rst_pulse_seen", 32'(seen), 32'd1);
        chk("post_rst_ce_count", 32'(edges), 32'(FRAME));
        chk("post_rst_fcnt", 32'(fc_p), 32'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
